// File: rtl/serdes_pkg.sv
// Shared types for the shift serdes: FSM state encoding.
// Pure declarations, no logic and no latency.
package serdes_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/bit_counter.sv
// Frame bit counter with terminal-count flag (tc when count == WIDTH-1).
// Registered count; enable on the terminal count returns it to zero, so it never runs past WIDTH-1.
module bit_counter #(
  parameter int WIDTH = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tc
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0] cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if (i_clear || (i_enable && o_tc)) begin
      cnt <= '0;
    end else if (i_enable) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign o_tc = (cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/shift_serdes.sv
// Full-duplex serialiser/deserialiser: one WIDTH-bit frame per handshake, one bit per i_tick.
// First bit is on o_sdata the cycle after the handshake; o_tx_ready is low for the whole frame.
module shift_serdes
  import serdes_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_tx_data,
  input  logic             i_tx_valid,
  output logic             o_tx_ready,
  input  logic             i_tick,
  input  logic             i_sdata,
  output logic             o_sdata,
  input  logic             i_abort,
  output logic             o_busy,
  output logic [WIDTH-1:0] o_rx_data,
  output logic             o_rx_valid
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] tx_sr;
  logic [WIDTH-1:0] rx_sr;
  logic [WIDTH-1:0] tx_shift;
  logic [WIDTH-1:0] rx_shift;
  logic             load;
  logic             tick_en;
  logic             last;
  logic             tc;

  assign load    = (state == IDLE) && i_tx_valid && o_tx_ready;
  // Abort wins over a coincident tick, including the final one.
  assign tick_en = (state == SHIFT) && i_tick && !i_abort;
  assign last    = tick_en && tc;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = SHIFT;
      SHIFT:   if (i_abort || last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_tx_ready = 1'b0;
    o_busy     = 1'b0;
    case (state)
      IDLE:    o_tx_ready = i_rst_n;
      SHIFT:   o_busy     = 1'b1;
      default: o_busy     = 1'b0;
    endcase
  end

  always_comb begin
    if (LSB_FIRST) begin
      tx_shift = {1'b0, tx_sr[WIDTH-1:1]};
      rx_shift = {i_sdata, rx_sr[WIDTH-1:1]};
    end else begin
      tx_shift = {tx_sr[WIDTH-2:0], 1'b0};
      rx_shift = {rx_sr[WIDTH-2:0], i_sdata};
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      tx_sr      <= '0;
      rx_sr      <= '0;
      o_sdata    <= 1'b0;
      o_rx_valid <= 1'b0;
      o_rx_data  <= '0;
    end else begin
      o_rx_valid <= last;
      if (load) begin
        tx_sr   <= i_tx_data;
        rx_sr   <= '0;
        o_sdata <= LSB_FIRST ? i_tx_data[0] : i_tx_data[WIDTH-1];
      end else if (tick_en) begin
        tx_sr   <= tx_shift;
        rx_sr   <= rx_shift;
        o_sdata <= last ? 1'b0 : (LSB_FIRST ? tx_shift[0] : tx_shift[WIDTH-1]);
        if (last) o_rx_data <= rx_shift;
      end else if ((state == SHIFT) && i_abort) begin
        o_sdata <= 1'b0;
      end
    end
  end

  bit_counter #(
    .WIDTH(WIDTH)
  ) u_bit_counter (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (load),
    .i_enable(tick_en),
    .o_tc    (tc)
  );

endmodule

// File: doc/shift_serdes.md
SHIFT_SERDES -- requirements
Module: shift_serdes

Interface
REQ-001 SHALL have parameter WIDTH, default 8, frame length in bits (legal range 2..32).
REQ-002 SHALL have parameter LSB_FIRST, default 0; 0 = MSB shifted first, 1 = LSB shifted first.
REQ-003 SHALL have port i_clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port i_tx_data  input  WIDTH  parallel word to transmit.
REQ-006 SHALL have port i_tx_valid  input  1  i_tx_data is valid.
REQ-007 SHALL have port o_tx_ready  output  1  block can accept a word.
REQ-008 SHALL have port i_tick  input  1  bit-rate enable, one bit per high cycle.
REQ-009 SHALL have port i_sdata  input  1  serial receive bit.
REQ-010 SHALL have port o_sdata  output  1  serial transmit bit.
REQ-011 SHALL have port i_abort  input  1  cancel the current frame.
REQ-012 SHALL have port o_busy  output  1  frame in progress.
REQ-013 SHALL have port o_rx_data  output  WIDTH  last completed received word.
REQ-014 SHALL have port o_rx_valid  output  1  single-cycle pulse, o_rx_data updated.

Function
REQ-015 SHALL implement two states: IDLE and SHIFT.
REQ-016 IDLE: o_tx_ready=1, o_busy=0, o_sdata=0, i_tick and i_abort ignored.
REQ-017 Handshake: transfer on i_tx_valid && o_tx_ready; word loaded into TX register, bit counter cleared, SHIFT entered next cycle.
REQ-018 SHIFT: o_tx_ready=0, o_busy=1; i_tx_valid ignored.
REQ-019 SHIFT: o_sdata SHALL present bit WIDTH-1 (LSB_FIRST=0) or bit 0 (LSB_FIRST=1) from the first SHIFT cycle, registered, stable between ticks.
REQ-020 Each SHIFT cycle with i_tick=1: i_sdata captured into RX register (enters at bit 0 if MSB-first, at bit WIDTH-1 if LSB-first), TX register advances one bit, counter increments.
REQ-021 The tick with counter==WIDTH-1 SHALL end the frame: IDLE next cycle, o_rx_data loaded with completed word and o_rx_valid=1 for exactly that cycle.
REQ-022 o_rx_data SHALL hold its value until the next completed frame.
REQ-023 Minimum one IDLE cycle between frames; i_tx_valid held high SHALL be accepted in the first IDLE cycle after completion.
REQ-024 i_abort=1 in SHIFT SHALL return to IDLE next cycle with no o_rx_valid and o_rx_data unchanged; i_abort takes priority over a simultaneous i_tick, including the final tick.
REQ-025 Counter width SHALL be $clog2(WIDTH); no wrap beyond WIDTH-1 is reachable.

Reset
REQ-026 While i_rst_n=0 at a clock edge: state=IDLE, counter=0, TX/RX registers=0, o_sdata=0, o_busy=0, o_rx_valid=0, o_rx_data=0.
REQ-027 o_tx_ready SHALL be 0 while i_rst_n=0 and 1 from the first cycle after release.
REQ-028 Reset mid-frame SHALL discard the frame with no o_rx_valid.

Structure
REQ-029 State encoding typedef (IDLE, SHIFT) SHALL live in shared package serdes_pkg.
REQ-030 Bit counter with terminal-count flag SHALL be sub-module bit_counter (parameter WIDTH, inputs clear/enable, output tc).
REQ-031 Target size 120-400 lines RTL; no latches; all outputs registered except o_tx_ready and o_busy (state decode).

Verification (WIDTH=8)
REQ-032 MSB-first, load 0xA5, i_tick=1 every cycle, o_sdata looped to i_sdata -> o_sdata 1,0,1,0,0,1,0,1; o_rx_valid one cycle after 8th tick, o_rx_data=0xA5.
REQ-033 LSB_FIRST=1, load 0x3C, i_sdata driven 0xC3 LSB-first -> o_sdata 0,0,1,1,1,1,0,0; o_rx_data=0xC3.
REQ-034 i_tick every 4th cycle, load 0x5A -> o_sdata changes only after ticks; o_rx_valid exactly once, one cycle after 8th tick; o_busy high throughout.
REQ-035 After a 0xA5 frame, start 0xFF, i_abort with 3rd tick -> IDLE next cycle, no o_rx_valid, o_rx_data stays 0xA5; next frame 0x0F completes normally.
REQ-036 i_rst_n=0 after 5 ticks -> all outputs 0 next cycle, no o_rx_valid; o_tx_ready=1 first cycle after release.
REQ-037 i_tx_valid held high with 0x01 then 0x80 -> second word accepted on first IDLE cycle after first o_rx_valid; i_tx_valid during SHIFT never loads.
